// File: rtl/multicycle_datapath.sv
// Multicycle RV32-subset datapath (RR/IMMEDIATE/LW/SW/BEQ): register file, ALU, PC and control FSM.
// Latency BEQ 3, RR/IMM/SW 4, LW 5 cycles; FETCH stalls on instrValid, MEM holds the request until dReady.
module multicycle_datapath #(
    parameter int          XLEN       = 32,
    parameter int          NUM_REGS   = 32,
    parameter logic [31:0] INITIAL_PC = 32'h00400000,
    parameter logic [6:0]  RR         = 7'b0110011,
    parameter logic [6:0]  IMMEDIATE  = 7'b0010011,
    parameter logic [6:0]  LW         = 7'b0000011,
    parameter logic [6:0]  SW         = 7'b0100011,
    parameter logic [6:0]  BEQ        = 7'b1100011
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instrValid,
    output logic            instrReq,
    output logic [XLEN-1:0] PC,
    input  logic [3:0]      ALUCtrl,
    output logic [XLEN-1:0] dAddress,
    output logic [XLEN-1:0] dWriteData,
    output logic            dRead,
    output logic            dWrite,
    input  logic [XLEN-1:0] dReadData,
    input  logic            dReady,
    output logic            Zero,
    output logic [XLEN-1:0] WriteBackData,
    output logic [2:0]      state,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [XLEN-1:0] PC_RST = XLEN'(INITIAL_PC);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    state_t          st;
    logic [31:0]     ir;
    logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
    logic [3:0]      ctrl_q;
    logic [XLEN-1:0] rf [NUM_REGS];

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       is_rr, is_imm, is_lw, is_sw, is_beq, known;
    logic       unused_funct3;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign is_rr  = (opcode == RR);
    assign is_imm = (opcode == IMMEDIATE);
    assign is_lw  = (opcode == LW);
    assign is_sw  = (opcode == SW);
    assign is_beq = (opcode == BEQ);
    assign known  = is_rr | is_imm | is_lw | is_sw | is_beq;
    assign unused_funct3 = ^ir[14:12];

    // x0 and indices beyond the implemented file read as zero
    logic [XLEN-1:0] rs1_val, rs2_val;
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0 && int'(rs1) < NUM_REGS) rs1_val = rf[rs1[RIW-1:0]];
        if (rs2 != '0 && int'(rs2) < NUM_REGS) rs2_val = rf[rs2[RIW-1:0]];
    end

    logic [XLEN-1:0] imm_i, imm_s, imm_b, dec_imm;
    assign imm_i = XLEN'($signed(ir[31:20]));
    assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));

    always_comb begin
        dec_imm = '0;
        if (is_imm || is_lw) dec_imm = imm_i;
        else if (is_sw)      dec_imm = imm_s;
        else if (is_beq)     dec_imm = imm_b;
    end

    logic [XLEN-1:0] op2, alu_res, wb_val, pc_plus4;
    logic [3:0]      ctrl_eff;
    logic [SHW-1:0]  shamt;
    logic            rd_ok;

    assign op2      = (is_imm || is_lw || is_sw) ? imm_q : b_q;
    assign ctrl_eff = is_beq ? 4'b0110 : ctrl_q;
    assign shamt    = op2[SHW-1:0];
    assign wb_val   = is_lw ? mdr_q : alu_q;
    assign pc_plus4 = PC + XLEN'(4);
    assign rd_ok    = (rd != '0) && (int'(rd) < NUM_REGS);

    always_comb begin
        alu_res = '0;
        case (ctrl_eff)
            4'b0000: alu_res = a_q & op2;
            4'b0001: alu_res = a_q | op2;
            4'b0010: alu_res = a_q + op2;
            4'b0110: alu_res = a_q - op2;
            4'b0111: alu_res = XLEN'($signed(a_q) < $signed(op2));
            4'b1000: alu_res = a_q >> shamt;
            4'b1001: alu_res = a_q << shamt;
            4'b1010: alu_res = $unsigned($signed(a_q) >>> shamt);
            4'b1101: alu_res = a_q ^ op2;
            default: alu_res = '0;
        endcase
    end

    // strobes decode the registered state, so reset drops them asynchronously
    assign instrReq = (st == FETCH);
    assign dRead    = (st == MEM) && is_lw;
    assign dWrite   = (st == MEM) && is_sw;
    assign state    = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st            <= FETCH;
            PC            <= PC_RST;
            ir            <= '0;
            a_q           <= '0;
            b_q           <= '0;
            imm_q         <= '0;
            alu_q         <= '0;
            mdr_q         <= '0;
            ctrl_q        <= '0;
            Zero          <= 1'b0;
            WriteBackData <= '0;
            dAddress      <= '0;
            dWriteData    <= '0;
            illegal       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            case (st)
                FETCH: begin
                    if (instrValid) begin
                        ir <= instr;
                        st <= DECODE;
                    end
                end
                DECODE: begin
                    a_q    <= rs1_val;
                    b_q    <= rs2_val;
                    imm_q  <= dec_imm;
                    ctrl_q <= ALUCtrl;
                    if (known) begin
                        st <= EXEC;
                    end else begin
                        st      <= TRAP;
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    alu_q <= alu_res;
                    Zero  <= (alu_res == '0);
                    if (is_beq) begin
                        PC <= (alu_res == '0) ? PC + imm_q : pc_plus4;
                        st <= FETCH;
                    end else if (is_lw || is_sw) begin
                        dAddress   <= alu_res;
                        dWriteData <= b_q;
                        st         <= MEM;
                    end else begin
                        st <= WB;
                    end
                end
                MEM: begin
                    if (dReady) begin
                        if (is_lw) begin
                            mdr_q <= dReadData;
                            st    <= WB;
                        end else begin
                            PC <= pc_plus4;
                            st <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (rd_ok) rf[rd[RIW-1:0]] <= wb_val;
                    WriteBackData <= wb_val;
                    PC            <= pc_plus4;
                    st            <= FETCH;
                end
                default: st <= TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed vector table, reset/trap sequences, and random
// instructions checked against an instruction-level reference model.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        instrValid = 1'b0;
    logic        instrReq;
    logic [31:0] PC;
    logic [3:0]  ALUCtrl = '0;
    logic [31:0] dAddress, dWriteData;
    logic        dRead, dWrite;
    logic [31:0] dReadData = '0;
    logic        dReady = 1'b0;
    logic        Zero;
    logic [31:0] WriteBackData;
    logic [2:0]  state;
    logic        illegal;

    multicycle_datapath dut (
        .clk(clk), .rst(rst), .instr(instr), .instrValid(instrValid), .instrReq(instrReq),
        .PC(PC), .ALUCtrl(ALUCtrl), .dAddress(dAddress), .dWriteData(dWriteData),
        .dRead(dRead), .dWrite(dWrite), .dReadData(dReadData), .dReady(dReady),
        .Zero(Zero), .WriteBackData(WriteBackData), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  ctrl;
        int          fw;
        int          mw;
        logic [31:0] ld;
        logic [31:0] pc;
        logic [31:0] wb;
        logic        zero;
        int          cyc;
        int          kind;   // 0 none, 1 load, 2 store
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        int          cyc;
        int          mem_cyc;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          unstable;
        bit          both;
        bit          timeout;
    } act_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_pc, m_wb;
    logic        m_zero;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return a >> b[4:0];
            4'b1001: return a << b[4:0];
            4'b1010: return 32'($signed(a) >>> b[4:0]);
            4'b1101: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_pc   = 32'h00400000;
        m_wb   = '0;
        m_zero = 1'b0;
    endtask

    // One instruction at ISA level: architectural effect plus the expected bus activity and timing
    task automatic model_step(input logic [31:0] ins, input logic [3:0] ctrl, input logic [31:0] ld,
                              input int fw, input int mw, output vec_t e);
        logic [31:0] v1, v2, immi, imms, immb, r;
        v1   = m_rf[ins[19:15]];
        v2   = m_rf[ins[24:20]];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e = '{ins, ctrl, fw, mw, ld, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0, 32'h0};
        r = '0;
        case (ins[6:0])
            7'b0110011, 7'b0010011: begin
                r = ref_alu(ctrl, v1, (ins[6:0] == 7'b0110011) ? v2 : immi);
                m_wb = r;
                if (ins[11:7] != 0) m_rf[ins[11:7]] = r;
                m_pc = m_pc + 4;
                e.cyc = 4 + fw;
            end
            7'b0000011: begin
                r = ref_alu(ctrl, v1, immi);
                e.kind = 1; e.addr = r; e.wdata = v2;
                m_wb = ld;
                if (ins[11:7] != 0) m_rf[ins[11:7]] = ld;
                m_pc = m_pc + 4;
                e.cyc = 5 + fw + mw;
            end
            7'b0100011: begin
                r = ref_alu(ctrl, v1, imms);
                e.kind = 2; e.addr = r; e.wdata = v2;
                m_pc = m_pc + 4;
                e.cyc = 4 + fw + mw;
            end
            default: begin
                r = v1 - v2;
                m_pc = (v1 == v2) ? m_pc + immb : m_pc + 4;
                e.cyc = 3 + fw;
            end
        endcase
        m_zero = (r == 0);
        e.pc   = m_pc;
        e.wb   = m_wb;
        e.zero = m_zero;
    endtask

    // Drives one instruction from FETCH until the next FETCH (or TRAP); called and returns at a negedge
    task automatic run(input logic [31:0] ins, input logic [3:0] ctrl, input int fwait, input int mwait,
                       input logic [31:0] ld, output act_t a);
        int fw = 0;
        int mw = 0;
        bit fetched = 0;
        bit done = 0;
        a = '{0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 100 && !done; k++) begin
            instrValid = 1'($urandom_range(0, 1));
            instr      = $urandom;
            ALUCtrl    = 4'($urandom);
            dReady     = 1'($urandom_range(0, 1));
            dReadData  = $urandom;
            if (dRead && dWrite) a.both = 1'b1;
            case (state)
                3'd0: begin
                    if (fetched) begin
                        done = 1;
                        instrValid = 1'b0;
                    end else begin
                        instr      = ins;
                        instrValid = (fw >= fwait);
                        if (instrValid) fetched = 1; else fw++;
                    end
                end
                3'd1: ALUCtrl = ctrl;
                3'd3: begin
                    a.mem_cyc++;
                    if (a.mem_cyc == 1) begin
                        a.rd = dRead; a.wr = dWrite; a.addr = dAddress; a.wdata = dWriteData;
                    end else if ({dRead, dWrite, dAddress, dWriteData} != {a.rd, a.wr, a.addr, a.wdata}) begin
                        a.unstable = 1'b1;
                    end
                    dReady    = (mw >= mwait);
                    dReadData = ld;
                    if (!dReady) mw++;
                end
                3'd7: done = 1;
                default: ;
            endcase
            if (!done) begin
                @(posedge clk);
                a.cyc++;
                @(negedge clk);
            end
        end
        a.timeout = !done;
    endtask

    task automatic compare_vec(input string tag, input vec_t e, input act_t a);
        chk({tag, " timeout"}, 32'(a.timeout), 32'd0);
        chk({tag, " latency"}, 32'(a.cyc), 32'(e.cyc));
        chk({tag, " pc"}, PC, e.pc);
        chk({tag, " wbdata"}, WriteBackData, e.wb);
        chk({tag, " zero"}, 32'(Zero), 32'(e.zero));
        chk({tag, " strobes"}, {30'd0, a.rd, a.wr},
            (e.kind == 1) ? 32'd2 : (e.kind == 2) ? 32'd1 : 32'd0);
        chk({tag, " both_strobes"}, 32'(a.both), 32'd0);
        if (e.kind != 0) begin
            chk({tag, " mem_cycles"}, 32'(a.mem_cyc), 32'(e.mw + 1));
            chk({tag, " daddr"}, a.addr, e.addr);
            chk({tag, " mem_stable"}, 32'(a.unstable), 32'd0);
            if (e.kind == 2) chk({tag, " dwdata"}, a.wdata, e.wdata);
        end
    endtask

    task automatic do_reset();
        instrValid = 1'b0;
        dReady     = 1'b0;
        rst        = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    vec_t        tbl [9];
    vec_t        e;
    act_t        a;
    logic [3:0]  ops [9];
    logic [6:0]  opc [5];
    logic [31:0] ins, pc_hold;
    logic [3:0]  ctrl;

    initial begin
        //          ins           ctrl fw mw ld            pc            wb            z  cyc kind addr          wdata
        tbl[0] = '{32'hFFB00093, 4'd2, 0, 0, 32'h0,        32'h00400004, 32'hFFFFFFFB, 0, 4, 0, 32'h0,        32'h0};
        tbl[1] = '{32'h00108133, 4'd2, 0, 0, 32'h0,        32'h00400008, 32'hFFFFFFF6, 0, 4, 0, 32'h0,        32'h0};
        tbl[2] = '{32'h0020A423, 4'd2, 0, 2, 32'h0,        32'h0040000C, 32'hFFFFFFF6, 0, 6, 2, 32'h00000003, 32'hFFFFFFF6};
        tbl[3] = '{32'hFFC0A183, 4'd2, 0, 0, 32'h12345678, 32'h00400010, 32'h12345678, 0, 5, 1, 32'hFFFFFFF7, 32'h0};
        tbl[4] = '{32'hFE108CE3, 4'd0, 0, 0, 32'h0,        32'h00400008, 32'h12345678, 1, 3, 0, 32'h0,        32'h0};
        tbl[5] = '{32'h00208463, 4'd0, 2, 0, 32'h0,        32'h0040000C, 32'h12345678, 0, 5, 0, 32'h0,        32'h0};
        tbl[6] = '{32'h00700013, 4'd2, 0, 0, 32'h0,        32'h00400010, 32'h00000007, 0, 4, 0, 32'h0,        32'h0};
        tbl[7] = '{32'h00000233, 4'd2, 0, 0, 32'h0,        32'h00400014, 32'h00000000, 1, 4, 0, 32'h0,        32'h0};
        tbl[8] = '{32'h00408293, 4'd10, 1, 0, 32'h0,       32'h00400018, 32'hFFFFFFFF, 0, 5, 0, 32'h0,        32'h0};
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
        opc = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

        // reset state while rst is held low
        repeat (2) @(negedge clk);
        chk("reset pc", PC, 32'h00400000);
        chk("reset state", 32'(state), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset zero", 32'(Zero), 32'd0);
        chk("reset wbdata", WriteBackData, 32'd0);
        chk("reset strobes", {30'd0, dRead, dWrite}, 32'd0);
        chk("reset daddr", dAddress, 32'd0);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].ins, tbl[i].ctrl, tbl[i].fw, tbl[i].mw, tbl[i].ld, a);
            model_step(tbl[i].ins, tbl[i].ctrl, tbl[i].ld, tbl[i].fw, tbl[i].mw, e);
            compare_vec($sformatf("dir%0d", i), tbl[i], a);
        end
        chk("dir x0", dut.rf[0], 32'h0);
        chk("dir x1", dut.rf[1], 32'hFFFFFFFB);
        chk("dir x2", dut.rf[2], 32'hFFFFFFF6);
        chk("dir x3", dut.rf[3], 32'h12345678);
        chk("dir x4", dut.rf[4], 32'h0);
        chk("dir x5", dut.rf[5], 32'hFFFFFFFF);

        // reset in the middle of an unanswered load
        dReady = 1'b0; instr = 32'h0000A303; instrValid = 1'b1;
        @(posedge clk); @(negedge clk);
        instrValid = 1'b0; ALUCtrl = 4'd2;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("midmem state", 32'(state), 32'd3);
        chk("midmem dread", 32'(dRead), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort dread", 32'(dRead), 32'd0);
        chk("abort pc", PC, 32'h00400000);
        chk("abort state", 32'(state), 32'd0);
        chk("abort illegal", 32'(illegal), 32'd0);
        chk("abort x1", dut.rf[1], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int n = 0; n < 150; n++) begin
            ins = $urandom;
            ins[6:0] = opc[$urandom_range(0, 4)];
            if (ins[6:0] == 7'b1100011 && $urandom_range(0, 2) == 0) ins[24:20] = ins[19:15];
            ctrl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 8)];
            e.fw = $urandom_range(0, 2);
            e.mw = $urandom_range(0, 2);
            e.ld = $urandom;
            run(ins, ctrl, e.fw, e.mw, e.ld, a);
            model_step(ins, ctrl, e.ld, e.fw, e.mw, e);
            compare_vec($sformatf("rnd%0d", n), e, a);
        end
        for (int i = 0; i < 32; i++) chk($sformatf("rnd x%0d", i), dut.rf[i], m_rf[i]);

        // unknown opcode: trap, no further fetches, PC frozen until reset
        pc_hold = PC;
        run(32'h0000007F, 4'd2, 0, 0, 32'h0, a);
        chk("trap timeout", 32'(a.timeout), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("trap state", 32'(state), 32'd7);
            chk("trap illegal", 32'(illegal), 32'd1);
            chk("trap instrreq", 32'(instrReq), 32'd0);
            chk("trap pc", PC, pc_hold);
            instrValid = 1'b1; instr = 32'h00100093; dReady = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("trap exit illegal", 32'(illegal), 32'd0);
        chk("trap exit state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
